serial_sub_8bit: RTL and testbench
==================================

Name: serial_sub_8bit

Overview:
- Bit-serial 8-bit subtractor with borrow-in/borrow-out; the subtract-direction counterpart of the team's 8-bit ripple-carry adder.
- Computes D = A − B − b_in using one full-subtractor cell, LSB first, over 8 clock cycles.
- Uses a start/done handshake so a sequencer or datapath controller can issue operations.
- Also reports a two's-complement overflow flag.

Parameters:
- WIDTH, 8: operand width and number of serial steps. Only 8 is verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge.
- B  input  WIDTH  subtrahend; sampled on the accepting edge.
- b_in  input  1  borrow-in; sampled on the accepting edge.
- D  output  WIDTH  difference; holds its value from DONE until the next accept.
- b_out  output  1  borrow-out. 1 means A < B + b_in, unsigned.
- ovf  output  1  signed overflow of A − B − b_in.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when D, b_out and ovf become valid.

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low (rst_n); all state is cleared immediately on assertion.
- Reset values: state=IDLE, D=0, b_out=0, ovf=0, busy=0, done=0, bit counter=0, internal borrow=0, operand shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: load A and B into shift registers, load b_in into the borrow flop, clear the counter, latch A[7]^B[7] for overflow, go to SHIFT.
- SHIFT: each edge processes bit i = counter:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the result register MSB-first position so that after 8 steps D[i] = d_i.
  - Operand registers shift right; the counter increments.
  - On the edge where counter = WIDTH−1 completes: D, b_out=br_next and ovf are updated together, then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge k → done high during the cycle after edge k+8. Next start may be accepted at edge k+10 at the earliest.
- Outputs are registered. D, b_out and ovf update only at the SHIFT→DONE transition; there are no partial results on D while SHIFT is running.
- ovf = (A[7] ^ B[7]) & (D[7] ^ A[7]), using latched A[7] and B[7]. b_in participates only through D.
- start while busy (SHIFT or DONE): ignored; the in-flight operation is unaffected and the request is not queued.
- A, B and b_in changing during SHIFT have no effect.
- Reset mid-operation: immediately return to reset values. No done pulse is produced for the aborted operation.
- Wrap-around: D is the result modulo 2^WIDTH. Borrow is reported only via b_out.

Test Plan:
- Reset, then A=0x00, B=0x01, b_in=0, start pulse → after 9 cycles done=1, D=0xFF, b_out=1, ovf=0.
- A=0x70, B=0x89, b_in=0 → D=0xE7, b_out=1, ovf=1. A=0xFE, B=0x8F, b_in=0 → D=0x6F, b_out=0, ovf=0.
- A=0x44, B=0x95, b_in=1 → D=0xAE, b_out=1, ovf=1. A=0x46, B=0xBB, b_in=1 → D=0x8A, b_out=1, ovf=1.
- Start with A=0x10, B=0x01, then hold start=1 with A=0xFF, B=0xFF for all of SHIFT → single done pulse with D=0x0F, b_out=0. The held start is accepted in the cycle after done, and the second result is D=0x00, b_out=0.
- Start A=0x55, B=0x22, b_in=0, assert rst_n=0 at step 4 → busy, done, D, b_out and ovf drop to 0 immediately. After release, the next operation A=0x05, B=0x03 → D=0x02.
- Random sweep of 1000 operand/borrow triples against a reference model → D, b_out and ovf match. done is exactly one cycle, 9 cycles after each accepted start.

Source files
------------

// File: rtl/serial_sub_8bit.sv
// serial_sub_8bit: bit-serial A - B - b_in, LSB first, one full-subtractor cell, start/done handshake
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request an operation, honoured only while idle
//   A, B   : minuend / subtrahend, captured on the accepting edge
//   b_in   : borrow-in, captured on the accepting edge
//   D      : difference mod 2^WIDTH, held from done until the next accept
//   b_out  : borrow-out (A < B + b_in, unsigned)
//   ovf    : two's-complement overflow of the subtraction
//   busy   : operation in flight (SHIFT or DONE)
//   done   : one-cycle pulse when D, b_out and ovf are valid
module serial_sub_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             b_in,
    output logic [WIDTH-1:0] D,
    output logic             b_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             br, sgn;
    logic             ai, bi, di, br_nx, last;

    assign ai    = a_sr[0];
    assign bi    = b_sr[0];
    assign di    = ai ^ bi ^ br;
    assign br_nx = (~ai & bi) | (~(ai ^ bi) & br);
    assign last  = cnt == CW'(WIDTH - 1);
    assign busy  = state != IDLE;
    assign done  = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? SHIFT : IDLE;
            SHIFT:   next = last ? DONE : SHIFT;
            default: next = IDLE;
        endcase
    end

    // At the final step a_sr[0] still holds the original A[MSB], so ovf needs
    // only the latched sign difference plus the new result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            sgn   <= 1'b0;
            D     <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= b_in;
            sgn  <= A[WIDTH-1] ^ B[WIDTH-1];
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= br_nx;
            res  <= {di, res[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            if (last) begin
                D     <= {di, res[WIDTH-1:1]};
                b_out <= br_nx;
                ovf   <= sgn & (di ^ ai);
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_8bit.sv
// tb_serial_sub_8bit: directed and random checks of serial_sub_8bit against an arithmetic model
module tb_serial_sub_8bit;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, b_in = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic [7:0] D;
    logic       b_out, ovf, busy, done;
    int         vectors = 0, miscompares = 0;

    serial_sub_8bit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .b_in(b_in),
        .D(D), .b_out(b_out), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned borrow and signed range overflow.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic bo, output logic ov);
        int u, s;
        u  = int'(a) - int'(b) - int'(bi);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        d  = 8'(u);
        bo = u < 0;
        ov = (s > 127) || (s < -128);
    endtask

    // Counts edges after the accepting edge until done; D must not move meanwhile.
    task automatic wait_done(input logic [7:0] hold_d, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            chk("d_hold", D, hold_d);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [7:0] ed, prev;
        logic       eb, eo;
        int         lat;
        model(a, b, bi, ed, eb, eo);
        prev  = D;
        A     = a;
        B     = b;
        b_in  = bi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        b_in  = 1'($urandom);
        chk("busy_shift", busy, 1);
        wait_done(prev, lat);
        chk("latency", lat, 8);
        chk("busy_done", busy, 1);
        chk("D", D, ed);
        chk("b_out", b_out, eb);
        chk("ovf", ovf, eo);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int lat;
        #2;
        chk("rst_D", D, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h00, 8'h01, 1'b0);
        chk("tp1_D", D, 8'hFF); chk("tp1_b", b_out, 1); chk("tp1_o", ovf, 0);
        run_op(8'h70, 8'h89, 1'b0);
        chk("tp2_D", D, 8'hE7); chk("tp2_b", b_out, 1); chk("tp2_o", ovf, 1);
        run_op(8'hFE, 8'h8F, 1'b0);
        chk("tp3_D", D, 8'h6F); chk("tp3_b", b_out, 0); chk("tp3_o", ovf, 0);
        run_op(8'h44, 8'h95, 1'b1);
        chk("tp4_D", D, 8'hAE); chk("tp4_b", b_out, 1); chk("tp4_o", ovf, 1);
        run_op(8'h46, 8'hBB, 1'b1);
        chk("tp5_D", D, 8'h8A); chk("tp5_b", b_out, 1); chk("tp5_o", ovf, 1);

        // start held high through the whole operation
        A = 8'h10; B = 8'h01; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        A = 8'hFF; B = 8'hFF;
        wait_done(8'h8A, lat);
        chk("held_lat1", lat, 8);
        chk("held_D1", D, 8'h0F);
        chk("held_b1", b_out, 0);
        @(posedge clk); #1;
        chk("held_single_pulse", done, 0);
        chk("held_idle", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_accept", busy, 1);
        wait_done(8'h0F, lat);
        chk("held_lat2", lat, 8);
        chk("held_D2", D, 8'h00);
        chk("held_b2", b_out, 0);
        @(posedge clk); #1;

        run_op(8'h46, 8'hBB, 1'b1);
        // reset in the middle of SHIFT
        A = 8'h55; B = 8'h22; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_D", D, 0);
        chk("mid_rst_b_out", b_out, 0);
        chk("mid_rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", done, 0);
        end
        run_op(8'h05, 8'h03, 1'b0);
        chk("post_rst_D", D, 8'h02);

        for (int i = 0; i < 1000; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
